// File: rtl/board_cursor.sv
// board_cursor: 2-D cursor over a ROWS x COLS board.
// Turns level-held buttons into single moves, supports linear step and
// up/down/left/right moves with runtime wrap-or-saturate edge handling,
// plus a direct level-sensitive load. Emits row, col, a registered 1-based
// linear index, and one-cycle moved/wrapped/blocked status pulses.
module board_cursor #(
  parameter  int ROWS = 5,
  parameter  int COLS = 5,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS),
  localparam int IW   = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          wrap_en,
  input  logic          step,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          load,
  input  logic [RW-1:0] load_row,
  input  logic [CW-1:0] load_col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [IW-1:0] index,
  output logic          moved,
  output logic          wrapped,
  output logic          blocked
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);

  logic step_prev, up_prev, down_prev, left_prev, right_prev;
  logic ev_step, ev_up, ev_down, ev_left, ev_right;
  logic load_ok;

  logic [RW-1:0] row_n;
  logic [CW-1:0] col_n;
  logic [IW-1:0] index_n;
  logic          moved_n, wrapped_n, blocked_n;

  // Rising-edge events: a held button fires only on the cycle it rises.
  assign ev_step  = step  & ~step_prev;
  assign ev_up    = up    & ~up_prev;
  assign ev_down  = down  & ~down_prev;
  assign ev_left  = left  & ~left_prev;
  assign ev_right = right & ~right_prev;

  // Compare with one extra bit so non-power-of-two boards reject codes >= size.
  assign load_ok = ({1'b0, load_row} < (RW+1)'(ROWS)) &&
                   ({1'b0, load_col} < (CW+1)'(COLS));

  // Button history tracks every cycle, independent of enable, so a button
  // already held when enable rises does not produce a move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_prev  <= 1'b0;
      up_prev    <= 1'b0;
      down_prev  <= 1'b0;
      left_prev  <= 1'b0;
      right_prev <= 1'b0;
    end else begin
      step_prev  <= step;
      up_prev    <= up;
      down_prev  <= down;
      left_prev  <= left;
      right_prev <= right;
    end
  end

  // Next position and status: one action per cycle, load > step > up >
  // down > left > right; lower-priority events in the same cycle are dropped.
  always_comb begin
    row_n     = row;
    col_n     = col;
    moved_n   = 1'b0;
    wrapped_n = 1'b0;
    blocked_n = 1'b0;
    if (enable) begin
      if (load) begin
        if (load_ok) begin
          row_n   = load_row;
          col_n   = load_col;
          moved_n = (load_row != row) || (load_col != col);
        end else begin
          blocked_n = 1'b1;
        end
      end else if (ev_step) begin
        if (col != COL_LAST) begin
          col_n   = col + CW'(1);
          moved_n = 1'b1;
        end else if (row != ROW_LAST) begin
          col_n   = '0;
          row_n   = row + RW'(1);
          moved_n = 1'b1;
        end else if (wrap_en) begin
          col_n     = '0;
          row_n     = '0;
          moved_n   = 1'b1;
          wrapped_n = 1'b1;
        end else begin
          blocked_n = 1'b1;
        end
      end else if (ev_up) begin
        if (row != '0) begin
          row_n   = row - RW'(1);
          moved_n = 1'b1;
        end else if (wrap_en) begin
          row_n     = ROW_LAST;
          moved_n   = 1'b1;
          wrapped_n = 1'b1;
        end else begin
          blocked_n = 1'b1;
        end
      end else if (ev_down) begin
        if (row != ROW_LAST) begin
          row_n   = row + RW'(1);
          moved_n = 1'b1;
        end else if (wrap_en) begin
          row_n     = '0;
          moved_n   = 1'b1;
          wrapped_n = 1'b1;
        end else begin
          blocked_n = 1'b1;
        end
      end else if (ev_left) begin
        if (col != '0) begin
          col_n   = col - CW'(1);
          moved_n = 1'b1;
        end else if (wrap_en) begin
          col_n     = COL_LAST;
          moved_n   = 1'b1;
          wrapped_n = 1'b1;
        end else begin
          blocked_n = 1'b1;
        end
      end else if (ev_right) begin
        if (col != COL_LAST) begin
          col_n   = col + CW'(1);
          moved_n = 1'b1;
        end else if (wrap_en) begin
          col_n     = '0;
          moved_n   = 1'b1;
          wrapped_n = 1'b1;
        end else begin
          blocked_n = 1'b1;
        end
      end
    end
  end

  // Index derives from the next position so the registered copy always
  // matches row/col; all terms are widened to IW bits before the multiply.
  assign index_n = IW'(row_n) * IW'(COLS) + IW'(col_n) + IW'(1);

  // Position, index and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row     <= '0;
      col     <= '0;
      index   <= IW'(1);
      moved   <= 1'b0;
      wrapped <= 1'b0;
      blocked <= 1'b0;
    end else begin
      row     <= row_n;
      col     <= col_n;
      index   <= index_n;
      moved   <= moved_n;
      wrapped <= wrapped_n;
      blocked <= blocked_n;
    end
  end

endmodule

// File: tb/tb_board_cursor.sv
// Testbench for board_cursor: a 5x5 and a 4x7 instance share stimulus and
// are checked every cycle against a behavioural cursor model, with a few
// hand-computed literal expectations anchoring the model.
module tb_board_cursor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1, wrap_en = 1'b1;
  logic step = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, load = 1'b0;
  logic [2:0] lr0 = '0, lc0 = '0;
  logic [1:0] lr1 = '0;
  logic [2:0] lc1 = '0;

  logic [2:0] row0, col0;
  logic [4:0] idx0;
  logic       mv0, wr0, bl0;
  logic [1:0] row1;
  logic [2:0] col1;
  logic [4:0] idx1;
  logic       mv1, wr1, bl1;

  int checks = 0;
  int failures = 0;

  // Model state: position and expected pulses per instance, plus button history.
  int  rr[2] = '{5, 4};
  int  cc[2] = '{5, 7};
  int  mr[2], mc[2];
  bit  mmv[2], mwr[2], mbl[2];
  bit  pv_step, pv_up, pv_down, pv_left, pv_right;

  always #5 clk = ~clk;

  board_cursor #(.ROWS(5), .COLS(5)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .wrap_en(wrap_en),
    .step(step), .up(up), .down(down), .left(left), .right(right),
    .load(load), .load_row(lr0), .load_col(lc0),
    .row(row0), .col(col0), .index(idx0),
    .moved(mv0), .wrapped(wr0), .blocked(bl0)
  );

  board_cursor #(.ROWS(4), .COLS(7)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .wrap_en(wrap_en),
    .step(step), .up(up), .down(down), .left(left), .right(right),
    .load(load), .load_row(lr1), .load_col(lc1),
    .row(row1), .col(col1), .index(idx1),
    .moved(mv1), .wrapped(wr1), .blocked(bl1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mr[i] = 0; mc[i] = 0; mmv[i] = 0; mwr[i] = 0; mbl[i] = 0;
    end
    pv_step = 0; pv_up = 0; pv_down = 0; pv_left = 0; pv_right = 0;
  endtask

  // Move one coordinate by d on an axis of n cells, wrapping or saturating.
  task automatic axis(input int v, input int n, input int d,
                      output int nv, output bit mv, output bit wr, output bit bl);
    int t;
    t = v + d;
    mv = 0; wr = 0; bl = 0; nv = v;
    if (t >= 0 && t < n) begin
      nv = t; mv = 1;
    end else if (wrap_en) begin
      nv = (t + n) % n; mv = 1; wr = 1;
    end else begin
      bl = 1;
    end
  endtask

  task automatic model_inst(input int i, input bit es, input bit eu, input bit ed,
                            input bit el, input bit er);
    int R, C, lr, lc, lin, nv;
    R = rr[i]; C = cc[i];
    lr = (i == 0) ? int'(lr0) : int'(lr1);
    lc = (i == 0) ? int'(lc0) : int'(lc1);
    mmv[i] = 0; mwr[i] = 0; mbl[i] = 0;
    if (!enable) return;
    if (load) begin
      if (lr < R && lc < C) begin
        mmv[i] = (lr != mr[i]) || (lc != mc[i]);
        mr[i] = lr; mc[i] = lc;
      end else begin
        mbl[i] = 1;
      end
    end else if (es) begin
      lin = mr[i] * C + mc[i];
      if (lin < R * C - 1) begin
        lin++; mmv[i] = 1;
      end else if (wrap_en) begin
        lin = 0; mmv[i] = 1; mwr[i] = 1;
      end else begin
        mbl[i] = 1;
      end
      mr[i] = lin / C; mc[i] = lin % C;
    end else if (eu) begin
      axis(mr[i], R, -1, nv, mmv[i], mwr[i], mbl[i]); mr[i] = nv;
    end else if (ed) begin
      axis(mr[i], R, 1, nv, mmv[i], mwr[i], mbl[i]); mr[i] = nv;
    end else if (el) begin
      axis(mc[i], C, -1, nv, mmv[i], mwr[i], mbl[i]); mc[i] = nv;
    end else if (er) begin
      axis(mc[i], C, 1, nv, mmv[i], mwr[i], mbl[i]); mc[i] = nv;
    end
  endtask

  task automatic model_update();
    bit es, eu, ed, el, er;
    es = step && !pv_step;
    eu = up && !pv_up;
    ed = down && !pv_down;
    el = left && !pv_left;
    er = right && !pv_right;
    for (int i = 0; i < 2; i++) model_inst(i, es, eu, ed, el, er);
    pv_step = step; pv_up = up; pv_down = down; pv_left = left; pv_right = right;
  endtask

  // One clock: model advances on the rising edge, control returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: step = v;
      1: up = v;
      2: down = v;
      3: left = v;
      default: right = v;
    endcase
  endtask

  task automatic do_load(input int r0, input int c0);
    lr0 = 3'(r0); lc0 = 3'(c0); load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("row0", row0, mr[0]);
      check("col0", col0, mc[0]);
      check("index0", idx0, mr[0] * 5 + mc[0] + 1);
      check("moved0", mv0, mmv[0]);
      check("wrapped0", wr0, mwr[0]);
      check("blocked0", bl0, mbl[0]);
      check("row1", row1, mr[1]);
      check("col1", col1, mc[1]);
      check("index1", idx1, mr[1] * 7 + mc[1] + 1);
      check("moved1", mv1, mmv[1]);
      check("wrapped1", wr1, mwr[1]);
      check("blocked1", bl1, mbl[1]);
    end
  end

  initial begin
    model_reset();
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_index0", idx0, 1);
    check("rst_row0", row0, 0);
    rst = 1'b1;
    tick();

    // Linear sweep with wrap.
    wrap_en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step = 1'b1;
      tick();
      if (k == 5) begin
        check("sweep_row_at6", row0, 1);
        check("sweep_col_at6", col0, 0);
        check("sweep_idx_at6", idx0, 6);
      end
      if (k == 25) begin
        check("sweep_idx_wrap", idx0, 1);
        check("sweep_wrapped", wr0, 1);
      end
      step = 1'b0;
      tick();
    end

    // Saturation at the far corner and at the origin.
    wrap_en = 1'b0;
    lr1 = 2'd3; lc1 = 3'd6;
    do_load(4, 4);
    for (int b = 0; b < 5; b++) begin
      if (b == 0 || b == 2 || b == 4) begin
        set_btn(b, 1'b1);
        tick();
        check("sat_blocked", bl0, 1);
        check("sat_moved", mv0, 0);
        check("sat_idx", idx0, 25);
        set_btn(b, 1'b0);
        tick();
      end
    end
    do_load(0, 0);
    for (int b = 1; b <= 3; b += 2) begin
      set_btn(b, 1'b1);
      tick();
      check("origin_blocked", bl0, 1);
      set_btn(b, 1'b0);
      tick();
    end

    // Wrapping directional moves.
    wrap_en = 1'b1;
    do_load(0, 2);
    up = 1'b1; tick();
    check("wrap_up_row", row0, 4);
    check("wrap_up_flag", wr0, 1);
    up = 1'b0; tick();
    do_load(3, 0);
    left = 1'b1; tick();
    check("wrap_left_col", col0, 4);
    check("wrap_left_idx", idx0, 20);
    left = 1'b0; tick();

    // Held input and enable gating.
    do_load(1, 1);
    right = 1'b1;
    repeat (10) tick();
    right = 1'b0; tick();
    check("held_col", col0, 2);
    enable = 1'b0; right = 1'b1; tick();
    enable = 1'b1;
    repeat (3) tick();
    right = 1'b0; tick();
    check("gated_col", col0, 2);

    // Priority and load behaviour.
    lr0 = 3'd2; lc0 = 3'd3; load = 1'b1; step = 1'b1; up = 1'b1;
    tick();
    check("prio_row", row0, 2);
    check("prio_col", col0, 3);
    check("prio_idx", idx0, 14);
    check("prio_moved", mv0, 1);
    load = 1'b0; step = 1'b0; up = 1'b0;
    tick();
    lr0 = 3'd5; lc0 = 3'd1; load = 1'b1;
    tick();
    check("load_oob_blocked", bl0, 1);
    check("load_oob_idx", idx0, 14);
    load = 1'b0; tick();
    lr0 = 3'd2; lc0 = 3'd3; load = 1'b1;
    tick();
    check("load_same_moved", mv0, 0);
    check("load_same_blocked", bl0, 0);
    load = 1'b0; tick();

    // Asynchronous reset between edges.
    do_load(3, 3);
    check("pre_rst_idx", idx0, 19);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("async_row", row0, 0);
    check("async_col", col0, 0);
    check("async_idx", idx0, 1);
    check("async_moved", mv0, 0);
    tick();
    rst = 1'b1;
    tick();

    // 4x7 board: last cell index and async reset.
    lr1 = 2'd3; lc1 = 3'd6; load = 1'b1;
    tick();
    check("b47_idx_last", idx1, 28);
    load = 1'b0;
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("b47_async_idx", idx1, 1);
    tick();
    rst = 1'b1;
    tick();

    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      step    = ($urandom_range(0, 2) == 0);
      up      = ($urandom_range(0, 3) == 0);
      down    = ($urandom_range(0, 3) == 0);
      left    = ($urandom_range(0, 3) == 0);
      right   = ($urandom_range(0, 3) == 0);
      load    = ($urandom_range(0, 9) == 0);
      enable  = ($urandom_range(0, 9) != 0);
      wrap_en = 1'($urandom_range(0, 1));
      lr0 = 3'($urandom_range(0, 7));
      lc0 = 3'($urandom_range(0, 7));
      lr1 = 2'($urandom_range(0, 3));
      lc1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_cursor.md
# board_cursor

Parametrised 2-D cursor over a ROWS×COLS game board, successor to the single-direction cell counter used during ship placement (FSM state 2). It converts level-held button inputs into single moves (internal rising-edge detection), supports linear step plus up/down/left/right moves, runtime-selectable wrap-around or saturation at the board edges, and direct load. It sits between the debounced button inputs and the placement/attack FSM, which consumes the row, column and 1-based linear cell index.

## Interface

Parameters:
- ROWS, 5, board rows; legal range 2..16.
- COLS, 5, board columns; legal range 2..16.

Derived widths: RW = $clog2(ROWS), CW = $clog2(COLS), IW = $clog2(ROWS*COLS+1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous and active-low.
- enable  input  1  when low, no move is accepted; edge history still tracked.
- wrap_en  input  1  1 = wrap at edges, 0 = saturate at edges.
- step  input  1  linear advance (row-major), level input, edge-detected.
- up, down, left, right  input  1 each  directional moves, level inputs, edge-detected.
- load  input  1  direct position load, level-sensitive, not edge-detected.
- load_row  input  RW  target row for load.
- load_col  input  CW  target column for load.
- row  output  RW  current row, 0..ROWS-1.
- col  output  CW  current column, 0..COLS-1.
- index  output  IW  1-based linear cell index = row*COLS + col + 1, range 1..ROWS*COLS; registered.
- moved  output  1  one-cycle pulse: position changed this cycle.
- wrapped  output  1  one-cycle pulse: the accepted move wrapped around an edge.
- blocked  output  1  one-cycle pulse: the accepted move was suppressed by saturation, or a load was out of range.

## Operation

- Edge detection: each of step/up/down/left/right has a previous-value register. ev_x = x & ~x_prev. The prev registers update every cycle regardless of enable, so a button already held when enable rises never fires.
- Request acceptance: one action per cycle. Priority: load > step > up > down > left > right. Lower-priority events in the same cycle are dropped, not queued. Requests are accepted only when enable=1.
- step: col+1. At col=COLS-1, col=0 and row+1. At the last cell (ROWS-1, COLS-1): wrap_en=1 → (0,0) with wrapped=1; wrap_en=0 → hold with blocked=1.
- up: row-1. At row 0, wrap_en=1 → ROWS-1 with wrapped=1; otherwise hold with blocked=1. down: row+1. At ROWS-1, wrap → 0, or hold.
- left: col-1. At col 0, wrap → COLS-1, or hold. right: col+1. At COLS-1, wrap → 0, or hold. Directional moves never change the other coordinate.
- load: if load_row<ROWS and load_col<COLS, the position is set, with moved=1 only if the new position differs from the current one. Otherwise the load is ignored and blocked=1. load while held reloads every cycle.
- moved is 1 for every accepted action that changes the position, including wraps. moved and blocked are mutually exclusive.
- index is computed from the next-state row/col and registered, so it is always coherent with row/col. Arithmetic uses IW bits with no truncation.

## Timing

- Reset (rst=0, asynchronous): row=0, col=0, index=1, moved=0, wrapped=0, blocked=0, all prev registers=0. Reset asserted mid-operation overrides everything immediately. The first edge after release may accept a move if an input is high (prev=0).
- Latency: an input that rises and is sampled high at edge k updates row/col/index and pulses moved, wrapped or blocked for exactly the cycle following edge k. Pulses are low on the next cycle unless a new action is accepted.
- A held input produces exactly one move. Re-triggering requires at least one cycle sampled low.
- Inputs are assumed synchronous to clk (already debounced and synchronised upstream).

## Test plan

- Reset/step sweep: after reset, 25 step pulses with wrap_en=1 (ROWS=COLS=5). index goes 2,3,…,25, then 1 at the 25th pulse. wrapped pulses only on the 25th pulse. Row/col at index 6 = (1,0).
- Saturation: at (4,4) with wrap_en=0, pulse step, down and right. Position stays (4,4), blocked pulses three times, moved never pulses. At (0,0), up and left each give blocked=1.
- Wrap directions: from (0,2) with wrap_en=1, up → (4,2) with wrapped=1. From (3,0), left → (3,4) with wrapped=1, and index=20.
- Held input and enable gating: hold right for 10 cycles → exactly one move. Raise right while enable=0, then raise enable with right still held → no move.
- Priority/load: same cycle load=1 with (2,3), step=1 and up rising → position (2,3), index=14, moved=1, step/up dropped. load (5,1) → ignored, blocked=1. load of the current position → moved=0, blocked=0.
- Async reset mid-move: assert rst low between clock edges while at (3,3) → outputs go to (0,0), index=1 and pulses 0 without waiting for a clock edge. Repeat with ROWS=4, COLS=7: index of (3,6) = 28.
